seven_seg_scanner: RTL and testbench

Parametrised successor to the fixed 8-digit seven-segment multiplexer. It time-multiplexes `N_DIGITS` common-anode digits from a packed nibble vector and decodes hex segments internally. It adds a double-buffered frame-synchronous load handshake, a per-digit blank mask, PWM brightness control and an optional leading-zero blanking feature. It sits between the mode/number-formatting logic (BCD, hex, time) and the board anode/cathode pins.

---
 rtl/seven_seg_scanner.sv | 145 ++++++++++++++
 tb/tb_seven_seg_scanner.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit common-anode hex display driver: double-buffered frame-synchronous
// load, per-digit blank mask and PWM dimming. Define SEVEN_SEG_LZB_EN for leading-zero blanking.
module seven_seg_scanner #(
    parameter int N_DIGITS = 8,
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int PWM_BITS = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [4*N_DIGITS-1:0] disp_value,
    input  logic [N_DIGITS-1:0]   dec_points,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic                  load,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic                  load_ack,
    output logic                  frame_start,
    output logic [N_DIGITS-1:0]   anode,
    output logic [7:0]            cathode
);
    localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int PRE_W    = $clog2(TICK_DIV);
    localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [PRE_W-1:0]      pre_cnt;
    logic [IDX_W-1:0]      idx;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [PWM_BITS-1:0]   brightness_q;
    logic [4*N_DIGITS-1:0] act_val, pend_val;
    logic [N_DIGITS-1:0]   act_dp, pend_dp;
    logic [N_DIGITS-1:0]   act_blank, pend_blank;
    logic                  pend_valid;
    logic                  tick, wrap, lit;
    logic [N_DIGITS-1:0]   lz_supp;
    logic [3:0]            cur_nib;
    logic [6:0]            cur_seg;
    logic [N_DIGITS-1:0]   anode_nxt;
    logic [7:0]            cathode_nxt;

    assign tick = (pre_cnt == PRE_W'(TICK_DIV - 1));
    assign wrap = tick && (idx == IDX_W'(N_DIGITS - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pre_cnt     <= '0;
            idx         <= '0;
            pwm_cnt     <= '0;
            act_val     <= '0;
            act_dp      <= '0;
            act_blank   <= '0;
            pend_val    <= '0;
            pend_dp     <= '0;
            pend_blank  <= '0;
            pend_valid  <= 1'b0;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
            anode       <= '1;
            cathode     <= 8'hFF;
        end else begin
            pre_cnt     <= tick ? '0 : pre_cnt + PRE_W'(1);
            pwm_cnt     <= pwm_cnt + PWM_BITS'(1);
            frame_start <= wrap;
            load_ack    <= 1'b0;
            anode       <= anode_nxt;
            cathode     <= cathode_nxt;
            if (tick)
                idx <= wrap ? '0 : idx + IDX_W'(1);
            // Fresh inputs on the wrap cycle bypass the pending buffer.
            if (wrap && load) begin
                act_val    <= disp_value;
                act_dp     <= dec_points;
                act_blank  <= blank_mask;
                pend_valid <= 1'b0;
                load_ack   <= 1'b1;
            end else if (wrap && pend_valid) begin
                act_val    <= pend_val;
                act_dp     <= pend_dp;
                act_blank  <= pend_blank;
                pend_valid <= 1'b0;
                load_ack   <= 1'b1;
            end else if (load) begin
                pend_val   <= disp_value;
                pend_dp    <= dec_points;
                pend_blank <= blank_mask;
                pend_valid <= 1'b1;
            end
        end
    end

    // Brightness is a live control, so it is retimed but never reset.
    always_ff @(posedge clock) begin
        brightness_q <= brightness;
    end

`ifdef SEVEN_SEG_LZB_EN
    logic lz_run;
    always_comb begin
        lz_supp = '0;
        lz_run  = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if (lz_run && act_val[i*4 +: 4] == 4'h0 && !act_dp[i])
                lz_supp[i] = 1'b1;
            else
                lz_run = 1'b0;
        end
    end
`else
    assign lz_supp = '0;
`endif

    assign cur_nib = act_val[{idx, 2'b00} +: 4];

    always_comb begin
        case (cur_nib)
            4'h0: cur_seg = 7'b1000000;
            4'h1: cur_seg = 7'b1111001;
            4'h2: cur_seg = 7'b0100100;
            4'h3: cur_seg = 7'b0110000;
            4'h4: cur_seg = 7'b0011001;
            4'h5: cur_seg = 7'b0010010;
            4'h6: cur_seg = 7'b0000010;
            4'h7: cur_seg = 7'b1111000;
            4'h8: cur_seg = 7'b0000000;
            4'h9: cur_seg = 7'b0010000;
            4'hA: cur_seg = 7'b0001000;
            4'hB: cur_seg = 7'b0000011;
            4'hC: cur_seg = 7'b1000110;
            4'hD: cur_seg = 7'b0100001;
            4'hE: cur_seg = 7'b0000110;
            default: cur_seg = 7'b0001110;
        endcase
    end

    assign lit = !act_blank[idx] && !lz_supp[idx] && (pwm_cnt < brightness_q);

    always_comb begin
        anode_nxt   = '1;
        cathode_nxt = 8'hFF;
        if (lit) begin
            anode_nxt   = ~(N_DIGITS'(1) << idx);
            cathode_nxt = {~act_dp[idx], cur_seg};
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: 4 digits, 4-cycle slots, 16-cycle frames
// aligned with the 16-step PWM period.
module tb_seven_seg_scanner;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] disp_value;
    logic [3:0]  dec_points, blank_mask;
    logic        load;
    logic [3:0]  brightness;
    logic        load_ack, frame_start;
    logic [3:0]  anode;
    logic [7:0]  cathode;

    int n_vec = 0, n_err = 0;
    int ack_total = 0, ack_misaligned = 0, exp_ack_total = 0;

    logic        sched_ld [16];
    logic [15:0] sched_val[16];
    logic [3:0]  sched_dp [16];
    logic [3:0]  sched_bl [16];

    always #5 clock = ~clock;

    seven_seg_scanner #(
        .N_DIGITS(4), .CLK_HZ(1000), .SCAN_HZ(250), .PWM_BITS(4)
    ) dut (
        .clock(clock), .reset_n(reset_n), .disp_value(disp_value),
        .dec_points(dec_points), .blank_mask(blank_mask), .load(load),
        .brightness(brightness), .load_ack(load_ack), .frame_start(frame_start),
        .anode(anode), .cathode(cathode)
    );

    always @(negedge clock) begin
        if (load_ack) begin
            ack_total++;
            if (!frame_start) ack_misaligned++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [3:0] lz_expect(input logic [15:0] v, input logic [3:0] dp);
        logic [3:0] s = 4'b0000;
`ifdef SEVEN_SEG_LZB_EN
        for (int i = 3; i >= 1; i--) begin
            if (v[i*4 +: 4] != 4'h0 || dp[i]) break;
            s[i] = 1'b1;
        end
`endif
        return s;
    endfunction

    task automatic clear_sched();
        for (int i = 0; i < 16; i++) begin
            sched_ld[i] = 1'b0; sched_val[i] = '0; sched_dp[i] = '0; sched_bl[i] = '0;
        end
    endtask

    task automatic sched(input int j, input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        sched_ld[j] = 1'b1; sched_val[j] = v; sched_dp[j] = dp; sched_bl[j] = bl;
    endtask

    // Entered at the negedge of a frame's first cycle; checks its 16 output cycles,
    // then the frame_start/load_ack pulse that opens the next frame.
    task automatic check_frame(input string tag, input logic [15:0] v, input logic [3:0] dp,
                               input logic [3:0] bl, input int br, input logic exp_ack,
                               input int new_br);
        logic [3:0]  sup = lz_expect(v, dp);
        logic [11:0] exp;
        int          d;
        for (int j = 0; j < 16; j++) begin
            @(negedge clock);
            d = j / 4;
            if (!bl[d] && !sup[d] && j < br)
                exp = {~(4'b0001 << d), ~dp[d], seg_of(v[d*4 +: 4])};
            else
                exp = {4'hF, 8'hFF};
            check($sformatf("%s c%0d", tag, j), {anode, cathode}, exp);
            load = sched_ld[j];
            if (sched_ld[j]) begin
                disp_value = sched_val[j]; dec_points = sched_dp[j]; blank_mask = sched_bl[j];
            end
            if (j == 14 && new_br >= 0) brightness = new_br[3:0];
        end
        check({tag, " frame_start"}, frame_start, 1);
        check({tag, " load_ack"}, load_ack, exp_ack);
        exp_ack_total += exp_ack;
        clear_sched();
    endtask

    initial begin
        clear_sched();
        reset_n = 1'b0; load = 1'b1; disp_value = 16'h8888;
        dec_points = 4'hF; blank_mask = 4'h0; brightness = 4'd15;
        repeat (5) @(negedge clock);
        check("rst anode", anode, 4'hF);
        check("rst cathode", cathode, 8'hFF);
        check("rst load_ack", load_ack, 0);
        check("rst frame_start", frame_start, 0);
        reset_n = 1'b1; load = 1'b0; dec_points = 4'h0;

        check_frame("post_rst", 16'h0000, 4'h0, 4'h0, 15, 1'b0, -1);
        sched(2, 16'h1A3F, 4'h0, 4'h0);
        check_frame("pre_scan", 16'h0000, 4'h0, 4'h0, 15, 1'b1, -1);
        sched(4, 16'h1111, 4'h0, 4'h0);
        sched(6, 16'h2222, 4'h0, 4'h0);
        check_frame("scan", 16'h1A3F, 4'h0, 4'h0, 15, 1'b1, -1);
        sched(14, 16'h8B74, 4'b0101, 4'h0);
        check_frame("buffer", 16'h2222, 4'h0, 4'h0, 15, 1'b1, -1);
        sched(3, 16'h96CE, 4'h0, 4'b0010);
        check_frame("wrap_load", 16'h8B74, 4'b0101, 4'h0, 15, 1'b1, -1);
        check_frame("blank", 16'h96CE, 4'h0, 4'b0010, 15, 1'b0, 8);
        check_frame("bright8", 16'h96CE, 4'h0, 4'b0010, 8, 1'b0, 0);
        check_frame("bright0", 16'h96CE, 4'h0, 4'b0010, 0, 1'b0, 15);

        repeat (6) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check("midrst anode", anode, 4'hF);
        check("midrst cathode", cathode, 8'hFF);
        check("midrst frame_start", frame_start, 0);
        reset_n = 1'b1;

        sched(2, 16'h0050, 4'h0, 4'h0);
        check_frame("after_rst", 16'h0000, 4'h0, 4'h0, 15, 1'b1, -1);
        sched(2, 16'h0050, 4'b1000, 4'h0);
        check_frame("lz", 16'h0050, 4'h0, 4'h0, 15, 1'b1, -1);
        check_frame("lz_dp", 16'h0050, 4'b1000, 4'h0, 15, 1'b0, -1);

        check("ack count", ack_total, exp_ack_total);
        check("ack off frame_start", ack_misaligned, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
